// File: rtl/timer_counter_if.sv
// ----------------------------------------------------------------------------
// timer_counter_if
//   M-stage bus between the system bridge and the countdown timer.
//   The bridge (master) drives a single-word access and the timer (slave)
//   returns combinational read data for the addressed register.
//
//   sel    bridge -> timer  access targets the timer this cycle
//   we     bridge -> timer  word store enable (only meaningful with sel)
//   addr   bridge -> timer  word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
//   wdata  bridge -> timer  store data
//   rdata  timer -> bridge  read data for addr, no latency
// ----------------------------------------------------------------------------
interface timer_counter_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output sel,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/timer_counter.sv
// ----------------------------------------------------------------------------
// timer_counter
//   Memory-mapped countdown timer sitting beside the data memory on the
//   M-stage bus. Software loads PRESET, then sets CTRL.EN; the timer loads
//   COUNT from PRESET, counts down to zero and raises an interrupt flag.
//   In auto-reload mode it reloads and runs again; in one-shot mode it clears
//   EN and parks with the flag held until software writes CTRL or PRESET.
//
//   Register map (word offsets):
//     0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, else one-shot), [3] IM
//     1 PRESET CNT_W bits, zero-extended on read
//     2 COUNT  read-only
//     3 reserved, reads 0, writes ignored
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     reset  synchronous, active-high
//     bus    timer_counter_if slave modport (sel/we/addr/wdata in, rdata out)
//     irq    registered interrupt request to CP0 (irq_flag & IM)
// ----------------------------------------------------------------------------
module timer_counter #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    timer_counter_if.slave     bus,
    output logic               irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_PRESET = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t           state, state_next;
    logic             en, en_next;
    logic [1:0]       mode, mode_next;
    logic             im, im_next;
    logic [CNT_W-1:0] preset, preset_next;
    logic [CNT_W-1:0] count, count_next;
    logic             irq_flag, irq_flag_next;
    logic             irq_next;

    logic             wr_ctrl;
    logic             wr_preset;
    logic             en_eff;
    logic             flag_set;
    logic             flag_clr_fsm;
    logic             en_clr_fsm;

    assign wr_ctrl   = bus.sel && bus.we && (bus.addr == OFS_CTRL);
    assign wr_preset = bus.sel && bus.we && (bus.addr == OFS_PRESET);

    // EN as it will be after this edge: a stop written during CNT freezes
    // COUNT at the value software just read instead of one tick later.
    assign en_eff = wr_ctrl ? bus.wdata[0] : en;

    // Read mux depends only on addr; the bridge decides whether to use it.
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            OFS_CTRL:   bus.rdata = {28'd0, im, mode, en};
            OFS_PRESET: bus.rdata = 32'(preset);
            OFS_COUNT:  bus.rdata = 32'(count);
            default:    bus.rdata = '0;
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_next   = state;
        count_next   = count;
        flag_set     = 1'b0;
        flag_clr_fsm = 1'b0;
        en_clr_fsm   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_next = preset;
                state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!en_eff) begin
                    state_next = ST_IDLE;
                end else if (count > CNT_W'(1)) begin
                    count_next = count - CNT_W'(1);
                end else begin
                    // Covers COUNT==1 and a PRESET of 0; never wraps below 0.
                    count_next = '0;
                    flag_set   = 1'b1;
                    state_next = ST_INT;
                end
            end
            ST_INT: begin
                if (mode == MODE_RELOAD) begin
                    flag_clr_fsm = 1'b1;
                    state_next   = ST_LOAD;
                end else begin
                    en_clr_fsm = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A CPU CTRL write overrides the one-shot EN clear in the same cycle.
        en_next   = en;
        mode_next = mode;
        im_next   = im;
        if (wr_ctrl) begin
            en_next   = bus.wdata[0];
            mode_next = bus.wdata[2:1];
            im_next   = bus.wdata[3];
        end else if (en_clr_fsm) begin
            en_next = 1'b0;
        end

        preset_next = wr_preset ? bus.wdata[CNT_W-1:0] : preset;

        // A CTRL/PRESET write acknowledges the interrupt and beats a
        // simultaneous expiry.
        irq_flag_next = irq_flag;
        if (wr_ctrl || wr_preset) begin
            irq_flag_next = 1'b0;
        end else if (flag_set) begin
            irq_flag_next = 1'b1;
        end else if (flag_clr_fsm) begin
            irq_flag_next = 1'b0;
        end

        // irq is a flop that mirrors irq_flag & IM of the registers it sits
        // beside, so no bus input reaches it combinationally.
        irq_next = irq_flag_next & im_next;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state    <= ST_IDLE;
            en       <= 1'b0;
            mode     <= 2'b00;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state    <= state_next;
            en       <= en_next;
            mode     <= mode_next;
            im       <= im_next;
            preset   <= preset_next;
            count    <= count_next;
            irq_flag <= irq_flag_next;
            irq      <= irq_next;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// ----------------------------------------------------------------------------
// tb_timer_counter
//   Directed bench for timer_counter. Inputs change 1 ns after a rising edge
//   and outputs are sampled in that same settled window. A store issued by
//   wr() takes effect on the next rising edge; "after edge t+k" below means
//   the value visible once k further edges have passed.
// ----------------------------------------------------------------------------
module tb_timer_counter;

    logic clk;
    logic reset;
    logic irq;

    timer_counter_if bus_if ();

    timer_counter #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.sel   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        step(1);
        bus_if.sel   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.wdata = '0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus_if.addr = a;
        #1;
        check(tag, bus_if.rdata, exp);
    endtask

    task automatic irq_is(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    // Expected COUNT / irq for auto-reload, PRESET=3, after edges t+1..t+12.
    logic [31:0] ar_count [1:12] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
    logic        ar_irq   [1:12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    initial begin
        bus_if.sel   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 2'd0;
        bus_if.wdata = '0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;

        // 1: reset values, CTRL upper bits ignored
        rd("rst_ctrl",   2'd0, 32'h0);
        rd("rst_preset", 2'd1, 32'h0);
        rd("rst_count",  2'd2, 32'h0);
        rd("rst_rsvd",   2'd3, 32'h0);
        irq_is("rst_irq", 1'b0);
        wr(2'd0, 32'hFFFF_FFFF);
        rd("ctrl_mask", 2'd0, 32'h0000_000F);
        wr(2'd0, 32'h0);
        step(3);
        irq_is("t1_irq_quiet", 1'b0);

        // 2: one-shot, PRESET=5, IM set
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);                    // edge t
        step(2);  rd("os_cnt5", 2'd2, 32'd5);
        step(1);  rd("os_cnt4", 2'd2, 32'd4);
        step(1);  rd("os_cnt3", 2'd2, 32'd3);
        step(1);  rd("os_cnt2", 2'd2, 32'd2);
        step(1);  rd("os_cnt1", 2'd2, 32'd1);
        irq_is("os_irq_pre", 1'b0);
        step(1);  rd("os_cnt0", 2'd2, 32'd0);
        irq_is("os_irq_int", 1'b1);
        step(1);  rd("os_en_clr", 2'd0, 32'h8);
        irq_is("os_irq_hold", 1'b1);
        step(3);  irq_is("os_irq_hold3", 1'b1);
        rd("os_cnt_stay0", 2'd2, 32'd0);
        wr(2'd0, 32'h8);
        irq_is("os_irq_ack", 1'b0);

        // 3: auto-reload, PRESET=3, IM set
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            rd($sformatf("ar_cnt_%0d", k), 2'd2, ar_count[k]);
            irq_is($sformatf("ar_irq_%0d", k), ar_irq[k]);
        end
        wr(2'd0, 32'h0);
        rd("ar_stop_hold", 2'd2, 32'd3);

        // 4: PRESET rewrite mid-count only affects the next reload (IM=0)
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h3);                    // edge t
        step(2);  rd("mc_cnt10", 2'd2, 32'd10);
        step(3);  rd("mc_cnt7", 2'd2, 32'd7);
        wr(2'd1, 32'd2);
        rd("mc_cnt6", 2'd2, 32'd6);
        step(1);  rd("mc_cnt5", 2'd2, 32'd5);
        step(5);  rd("mc_cnt0", 2'd2, 32'd0);
        irq_is("mc_irq_masked", 1'b0);
        step(2);  rd("mc_reload2", 2'd2, 32'd2);
        wr(2'd0, 32'h0);
        step(1);

        // 4b: stop at COUNT=4 freezes it, no interrupt
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);
        step(2);  rd("stop_cnt6", 2'd2, 32'd6);
        step(2);  rd("stop_cnt4", 2'd2, 32'd4);
        wr(2'd0, 32'h0);
        rd("stop_hold_a", 2'd2, 32'd4);
        step(3);  rd("stop_hold_b", 2'd2, 32'd4);
        irq_is("stop_irq", 1'b0);

        // 5: IM=0 expiry keeps irq low; a later CTRL write acknowledges the flag
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        step(4);  rd("im0_cnt0", 2'd2, 32'd0);
        irq_is("im0_irq_int", 1'b0);
        step(1);  rd("im0_en_clr", 2'd0, 32'h0);
        irq_is("im0_irq_idle", 1'b0);
        wr(2'd0, 32'h8);
        rd("im0_ctrl_im", 2'd0, 32'h8);
        irq_is("im0_irq_acked", 1'b0);

        // Expiry and PRESET write in the same cycle: the write wins
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        step(3);  rd("ww_cnt1", 2'd2, 32'd1);
        wr(2'd1, 32'd7);
        rd("ww_cnt0", 2'd2, 32'd0);
        irq_is("ww_irq", 1'b0);
        step(1);  rd("ww_en_clr", 2'd0, 32'h8);
        irq_is("ww_irq_later", 1'b0);

        // CTRL write in the INT cycle beats the one-shot EN clear (PRESET=1)
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        step(3);  rd("int_cnt0", 2'd2, 32'd0);
        irq_is("int_irq", 1'b1);
        wr(2'd0, 32'h9);
        rd("int_en_kept", 2'd0, 32'h9);
        irq_is("int_irq_ack", 1'b0);
        step(2);  rd("int_rerun", 2'd2, 32'd1);
        wr(2'd0, 32'h0);
        step(2);

        // PRESET=0 behaves as 1
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(2);  irq_is("p0_irq_cnt", 1'b0);
        step(1);  irq_is("p0_irq_int", 1'b1);
        rd("p0_cnt", 2'd2, 32'd0);
        wr(2'd0, 32'h0);

        // MODE=11 behaves as one-shot
        wr(2'd1, 32'd1);
        wr(2'd0, 32'hF);
        step(3);  irq_is("m3_irq", 1'b1);
        step(1);  rd("m3_en_clr", 2'd0, 32'hE);
        wr(2'd0, 32'h0);

        // 6: reset mid-count
        wr(2'd1, 32'd5);
        wr(2'd0, 32'hB);
        step(4);  rd("rm_cnt3", 2'd2, 32'd3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rd("rm_ctrl",   2'd0, 32'h0);
        rd("rm_preset", 2'd1, 32'h0);
        rd("rm_count",  2'd2, 32'h0);
        irq_is("rm_irq", 1'b0);

        // Writes to offsets 2 and 3 are ignored
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        step(2);  rd("ro_cnt4", 2'd2, 32'd4);
        wr(2'd2, 32'h1234);
        rd("ro_cnt3", 2'd2, 32'd3);
        wr(2'd3, 32'hFFFF_FFFF);
        rd("ro_cnt2",    2'd2, 32'd2);
        rd("ro_ctrl",    2'd0, 32'h1);
        rd("ro_preset",  2'd1, 32'd4);
        rd("ro_rsvd",    2'd3, 32'h0);
        step(2);  rd("ro_cnt0", 2'd2, 32'd0);
        irq_is("ro_irq", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
